// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state types for the JPU UART.
//   UART_DATA_WIDTH          payload bits per frame
//   WORD_SIZE                width of the bit-period divider
//   UART_MIN_DIVIDE          smallest usable cycles-per-bit value
//   UART_DIVIDE_OVERRIDE_SIM divider used by fast simulation setups
//   tx_state_e / rx_state_e  engine state encodings
package uart_pkg;

  localparam int UART_DATA_WIDTH          = 8;
  localparam int WORD_SIZE                = 32;
  localparam int UART_MIN_DIVIDE          = 4;
  localparam int UART_DIVIDE_OVERRIDE_SIM = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: down-counter that measures one bit period (or half of one).
//   clk, rst    clock and synchronous active-low reset
//   load        restart the count with load_value
//   load_value  number of cycles until the next tick (>= 2)
//   tick        high during the last cycle of the loaded period
module uart_bit_timer #(
  parameter int WORD_SIZE = uart_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] load_value,
  output logic                 tick
);

  logic [WORD_SIZE-1:0] cnt;

  // Loading value-1 makes tick land exactly load_value cycles after the load,
  // so the owning FSM can reload on tick and keep periods back to back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value - 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling.
//   clk, rst       clock and synchronous active-low reset
//   uart_divide    cycles per bit, clamped to UART_MIN_DIVIDE, latched per frame
//   rxd            asynchronous serial input
//   uart_rx_data   last good byte, held between frames
//   uart_rx_valid  one-cycle pulse for a good frame
//   uart_rx_err    one-cycle pulse for a frame whose stop bit was low
module uart_rx #(
  parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH,
  parameter int WORD_SIZE  = uart_pkg::WORD_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  uart_divide,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] uart_rx_data,
  output logic                  uart_rx_valid,
  output logic                  uart_rx_err
);

  import uart_pkg::*;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [WORD_SIZE-1:0] MIN_N = WORD_SIZE'(UART_MIN_DIVIDE);

  rx_state_e state, state_next;
  logic [WORD_SIZE-1:0]  n_eff, n_lat, load_value;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic sync1, sync2;
  logic wait_high, arm, load, tick, valid_next, err_next;

  assign n_eff = (uart_divide < MIN_N) ? MIN_N : uart_divide;
  // After a framing error the line may still be low; wait_high keeps that
  // level from being mistaken for a fresh start bit.
  assign arm   = (state == RX_IDLE) && !wait_high && !sync2;
  assign load  = arm || ((state != RX_IDLE) && tick);
  // Half a period first to reach the middle of the start bit, then whole
  // periods from there on.
  assign load_value = arm ? (n_eff >> 1) : n_lat;

  uart_bit_timer #(.WORD_SIZE(WORD_SIZE)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .tick       (tick)
  );

  // State register, input synchronizer, sample shifter and registered pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      state         <= RX_IDLE;
      n_lat         <= MIN_N;
      shreg         <= '0;
      bit_idx       <= '0;
      wait_high     <= 1'b0;
      uart_rx_data  <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_err   <= 1'b0;
    end else begin
      sync1         <= rxd;
      sync2         <= sync1;
      state         <= state_next;
      uart_rx_valid <= valid_next;
      uart_rx_err   <= err_next;
      if (arm) begin
        n_lat   <= n_eff;
        bit_idx <= '0;
      end
      if ((state == RX_DATA) && tick) begin
        shreg   <= {sync2, shreg[DATA_WIDTH-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (valid_next) uart_rx_data <= shreg;
      if (err_next) begin
        wait_high <= 1'b1;
      end else if ((state == RX_IDLE) && sync2) begin
        wait_high <= 1'b0;
      end
    end
  end

  // Next-state logic: a start bit that is high again at mid-bit was a glitch.
  always_comb begin
    state_next = state;
    unique case (state)
      RX_IDLE:  if (arm) state_next = RX_START;
      RX_START: if (tick) state_next = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && (bit_idx == LAST_IDX)) state_next = RX_STOP;
      RX_STOP:  if (tick) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Output decode: the stop-bit sample decides between valid and error.
  always_comb begin
    valid_next = 1'b0;
    err_next   = 1'b0;
    if ((state == RX_STOP) && tick) begin
      valid_next = sync2;
      err_next   = !sync2;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter.
//   clk, rst       clock and synchronous active-low reset
//   uart_divide    cycles per bit, clamped to UART_MIN_DIVIDE, latched per frame
//   uart_tx_data   byte to send, captured on the handshake
//   uart_tx_valid  send request; ignored while the engine is busy
//   uart_tx_ready  registered idle indication
//   txd            registered serial output, idles high
module uart_tx #(
  parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH,
  parameter int WORD_SIZE  = uart_pkg::WORD_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  uart_divide,
  input  logic [DATA_WIDTH-1:0] uart_tx_data,
  input  logic                  uart_tx_valid,
  output logic                  uart_tx_ready,
  output logic                  txd
);

  import uart_pkg::*;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [WORD_SIZE-1:0] MIN_N = WORD_SIZE'(UART_MIN_DIVIDE);

  tx_state_e state, state_next;
  logic [WORD_SIZE-1:0]  n_eff, n_lat, load_value;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic accept, load, tick, txd_next, ready_next;

  assign n_eff  = (uart_divide < MIN_N) ? MIN_N : uart_divide;
  // ready is registered one cycle behind the state, so the state check keeps
  // the cycle right after a handshake from accepting a second byte.
  assign accept = (state == TX_IDLE) && uart_tx_valid && uart_tx_ready;
  assign load   = accept || ((state != TX_IDLE) && tick);
  // The divider is latched on the handshake, so the first period uses the
  // live value and all later periods of the frame use the latched copy.
  assign load_value = accept ? n_eff : n_lat;

  uart_bit_timer #(.WORD_SIZE(WORD_SIZE)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .tick       (tick)
  );

  // State register plus frame datapath and the registered outputs, which
  // therefore follow the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= TX_IDLE;
      n_lat         <= MIN_N;
      shreg         <= '0;
      bit_idx       <= '0;
      txd           <= 1'b1;
      uart_tx_ready <= 1'b0;
    end else begin
      state         <= state_next;
      txd           <= txd_next;
      uart_tx_ready <= ready_next;
      if (accept) begin
        n_lat   <= n_eff;
        shreg   <= uart_tx_data;
        bit_idx <= '0;
      end else if ((state == TX_DATA) && tick) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Next-state logic: every non-idle state lasts one bit period.
  always_comb begin
    state_next = state;
    unique case (state)
      TX_IDLE:  if (accept) state_next = TX_START;
      TX_START: if (tick) state_next = TX_DATA;
      TX_DATA:  if (tick && (bit_idx == LAST_IDX)) state_next = TX_STOP;
      TX_STOP:  if (tick) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // Output decode: line level for the current state, registered above.
  always_comb begin
    txd_next   = 1'b1;
    ready_next = 1'b0;
    unique case (state)
      TX_IDLE:  ready_next = 1'b1;
      TX_START: txd_next   = 1'b0;
      TX_DATA:  txd_next   = shreg[0];
      TX_STOP:  txd_next   = 1'b1;
      default:  txd_next   = 1'b1;
    endcase
  end

endmodule

// File: rtl/jpu_uart.sv
// jpu_uart: 8N1 UART transceiver sharing one programmable bit-period divider.
//   clk, rst                     clock and synchronous active-low reset
//   uart_divide                  cycles per bit (clamped to a minimum of 4)
//   uart_tx_data/valid/ready     byte-level transmit handshake
//   txd                          serial output, idles high
//   rxd                          serial input, asynchronous
//   uart_rx_data/valid/err       received byte, good-frame and framing-error pulses
module jpu_uart #(
  parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH,
  parameter int WORD_SIZE  = uart_pkg::WORD_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  uart_divide,
  input  logic [DATA_WIDTH-1:0] uart_tx_data,
  input  logic                  uart_tx_valid,
  output logic                  uart_tx_ready,
  output logic                  txd,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] uart_rx_data,
  output logic                  uart_rx_valid,
  output logic                  uart_rx_err
);

  uart_tx #(.DATA_WIDTH(DATA_WIDTH), .WORD_SIZE(WORD_SIZE)) u_tx (
    .clk           (clk),
    .rst           (rst),
    .uart_divide   (uart_divide),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .txd           (txd)
  );

  uart_rx #(.DATA_WIDTH(DATA_WIDTH), .WORD_SIZE(WORD_SIZE)) u_rx (
    .clk           (clk),
    .rst           (rst),
    .uart_divide   (uart_divide),
    .rxd           (rxd),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_err   (uart_rx_err)
  );

endmodule

// File: tb/tb_jpu_uart.sv
// tb_jpu_uart: directed, table-driven bench for jpu_uart.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_jpu_uart;

  logic        clk;
  logic        rst;
  logic [31:0] uart_divide;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic        txd;
  logic        rxd;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_err;

  logic loop_en;
  logic rxd_drv;

  int n_compared;
  int n_mismatched;
  logic [7:0] rx_q[$];
  int err_count;

  typedef struct {
    logic [31:0] divide;
    logic [7:0]  data;
    int          neff;
    int          exp_latency;
    logic [9:0]  exp_frame;
  } vec_t;

  vec_t vecs[7];

  assign rxd = loop_en ? txd : rxd_drv;

  jpu_uart dut (
    .clk           (clk),
    .rst           (rst),
    .uart_divide   (uart_divide),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .txd           (txd),
    .rxd           (rxd),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_err   (uart_rx_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Receive monitor: records every good byte and counts framing errors
  always @(negedge clk) begin
    if (uart_rx_valid) rx_q.push_back(uart_rx_data);
    if (uart_rx_err) err_count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one byte through the handshake; returns cycles until ready comes
  // back and the mid-bit samples of the ten frame slots seen on txd.
  task automatic applyStimulus(input logic [7:0] data, input int n,
                               output int latency, output logic [9:0] frame);
    int c;
    int guard;
    frame = '1;
    guard = 0;
    while (!uart_tx_ready && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("tx_ready_before_send", 32'(uart_tx_ready), 32'd1);
    uart_tx_data  = data;
    uart_tx_valid = 1'b1;
    @(negedge clk);
    uart_tx_valid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      for (int s = 0; s < 10; s++)
        if (c == 1 + s * n + n / 2) frame[s] = txd;
    end while (!uart_tx_ready && c < 20 * n + 100);
    latency = c;
  endtask

  // Drives one frame on rxd from the bench side
  task automatic driveFrame(input logic [7:0] data, input logic stop_bit, input int n);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int s = 0; s < 10; s++) begin
      rxd_drv = bits[s];
      waitCycles(n);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    int lat;
    logic [9:0] frm;
    int v0;
    int e0;
    logic [7:0] got;
    logic [7:0] held;
    logic [7:0] msg [3];
    int c;

    n_compared    = 0;
    n_mismatched  = 0;
    err_count     = 0;
    rst           = 1'b0;
    loop_en       = 1'b1;
    rxd_drv       = 1'b1;
    uart_divide   = 32'd16;
    uart_tx_data  = 8'h00;
    uart_tx_valid = 1'b0;

    vecs[0] = '{32'd16, 8'h41, 16, 161, {1'b1, 8'h41, 1'b0}};
    vecs[1] = '{32'd16, 8'h00, 16, 161, {1'b1, 8'h00, 1'b0}};
    vecs[2] = '{32'd16, 8'hFF, 16, 161, {1'b1, 8'hFF, 1'b0}};
    vecs[3] = '{32'd4,  8'hA5, 4,  41,  {1'b1, 8'hA5, 1'b0}};
    vecs[4] = '{32'd2,  8'h3C, 4,  41,  {1'b1, 8'h3C, 1'b0}};
    vecs[5] = '{32'd7,  8'h80, 7,  71,  {1'b1, 8'h80, 1'b0}};
    vecs[6] = '{32'd5,  8'h01, 5,  51,  {1'b1, 8'h01, 1'b0}};

    // Reset state
    waitCycles(3);
    checkOutput("reset_txd", 32'(txd), 32'd1);
    checkOutput("reset_ready", 32'(uart_tx_ready), 32'd0);
    checkOutput("reset_rx_data", 32'(uart_rx_data), 32'd0);
    checkOutput("reset_rx_valid", 32'(uart_rx_valid), 32'd0);
    checkOutput("reset_rx_err", 32'(uart_rx_err), 32'd0);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("ready_after_release", 32'(uart_tx_ready), 32'd1);

    // Loopback table
    for (int i = 0; i < 7; i++) begin
      uart_divide = vecs[i].divide;
      v0 = rx_q.size();
      e0 = err_count;
      applyStimulus(vecs[i].data, vecs[i].neff, lat, frm);
      waitCycles(2 * vecs[i].neff + 10);
      got = (rx_q.size() > v0) ? rx_q[v0] : 8'hxx;
      checkOutput($sformatf("vec%0d_frame", i), 32'(frm), 32'(vecs[i].exp_frame));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_latency));
      checkOutput($sformatf("vec%0d_valid_count", i), 32'(rx_q.size() - v0), 32'd1);
      checkOutput($sformatf("vec%0d_rx_data", i), 32'(got), 32'(vecs[i].data));
      checkOutput($sformatf("vec%0d_err_count", i), 32'(err_count - e0), 32'd0);
    end

    // Back-to-back "Aq\n", each byte on the first ready cycle
    uart_divide = 32'd16;
    msg[0] = 8'h41;
    msg[1] = 8'h71;
    msg[2] = 8'h0A;
    v0 = rx_q.size();
    e0 = err_count;
    for (int i = 0; i < 3; i++) applyStimulus(msg[i], 16, lat, frm);
    waitCycles(50);
    checkOutput("b2b_valid_count", 32'(rx_q.size() - v0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (rx_q.size() > v0 + i) ? rx_q[v0 + i] : 8'hxx;
      checkOutput($sformatf("b2b_byte%0d", i), 32'(got), 32'(msg[i]));
    end
    checkOutput("b2b_err_count", 32'(err_count - e0), 32'd0);

    // Framing error: stop bit low, line held low for a while
    loop_en = 1'b0;
    held = uart_rx_data;
    v0 = rx_q.size();
    e0 = err_count;
    driveFrame(8'h55, 1'b0, 16);
    rxd_drv = 1'b0;
    waitCycles(40);
    rxd_drv = 1'b1;
    waitCycles(40);
    checkOutput("ferr_err_count", 32'(err_count - e0), 32'd1);
    checkOutput("ferr_valid_count", 32'(rx_q.size() - v0), 32'd0);
    checkOutput("ferr_rx_data_held", 32'(uart_rx_data), 32'(held));
    driveFrame(8'h5A, 1'b1, 16);
    waitCycles(20);
    checkOutput("ferr_rearm_valid", 32'(rx_q.size() - v0), 32'd1);
    checkOutput("ferr_rearm_data", 32'(uart_rx_data), 32'h5A);

    // Glitch: 5-cycle low pulse must be rejected
    v0 = rx_q.size();
    e0 = err_count;
    rxd_drv = 1'b0;
    waitCycles(5);
    rxd_drv = 1'b1;
    waitCycles(60);
    checkOutput("glitch_valid_count", 32'(rx_q.size() - v0), 32'd0);
    checkOutput("glitch_err_count", 32'(err_count - e0), 32'd0);
    driveFrame(8'hC3, 1'b1, 16);
    waitCycles(20);
    checkOutput("glitch_then_frame", 32'(uart_rx_data), 32'hC3);

    // Request while busy is dropped
    loop_en = 1'b1;
    v0 = rx_q.size();
    e0 = err_count;
    uart_tx_data  = 8'h11;
    uart_tx_valid = 1'b1;
    @(negedge clk);
    uart_tx_valid = 1'b0;
    waitCycles(50);
    uart_tx_data  = 8'h22;
    uart_tx_valid = 1'b1;
    @(negedge clk);
    uart_tx_valid = 1'b0;
    c = 0;
    while (!uart_tx_ready && c < 400) begin
      @(negedge clk);
      c++;
    end
    checkOutput("drop_ready_returns", 32'(uart_tx_ready), 32'd1);
    waitCycles(200);
    got = (rx_q.size() > v0) ? rx_q[v0] : 8'hxx;
    checkOutput("drop_valid_count", 32'(rx_q.size() - v0), 32'd1);
    checkOutput("drop_rx_data", 32'(got), 32'h11);
    checkOutput("drop_err_count", 32'(err_count - e0), 32'd0);

    // Reset during the 4th data bit
    v0 = rx_q.size();
    e0 = err_count;
    uart_tx_data  = 8'h5A;
    uart_tx_valid = 1'b1;
    @(negedge clk);
    uart_tx_valid = 1'b0;
    waitCycles(1 + 4 * 16 + 8);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("midrst_txd", 32'(txd), 32'd1);
    checkOutput("midrst_ready_low", 32'(uart_tx_ready), 32'd0);
    waitCycles(2);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("midrst_ready_after", 32'(uart_tx_ready), 32'd1);
    checkOutput("midrst_rx_data", 32'(uart_rx_data), 32'd0);
    waitCycles(300);
    checkOutput("midrst_valid_count", 32'(rx_q.size() - v0), 32'd0);
    checkOutput("midrst_err_count", 32'(err_count - e0), 32'd0);
    checkOutput("midrst_txd_idle", 32'(txd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/jpu_uart.md
# jpu_uart

UART transceiver for the JPU: one 8N1 serial transmitter and one 8N1 serial receiver. Both share a runtime-programmable bit-period divider. The block sits between the JPU core's byte-level UART interface and the board's `txd`/`rxd` pins. The same block also serves as the bench-side UART model that drives and monitors the processor's serial lines.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `WORD_SIZE`, default 32: width of `uart_divide`.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `uart_divide`, in, `WORD_SIZE`: clock cycles per bit (N).
- `uart_tx_data`, in, `DATA_WIDTH`: byte to transmit.
- `uart_tx_valid`, in, 1: transmit request.
- `uart_tx_ready`, out, 1: transmitter idle and able to accept a byte.
- `txd`, out, 1: serial output; idles high.
- `rxd`, in, 1: serial input; asynchronous.
- `uart_rx_data`, out, `DATA_WIDTH`: last received byte.
- `uart_rx_valid`, out, 1: one-cycle pulse when a good frame is received.
- `uart_rx_err`, out, 1: one-cycle pulse on a framing error.

## Operation
- Frame format: 1 start bit (0), `DATA_WIDTH` data bits LSB first, 1 stop bit (1). No parity.
- Divider: N = `uart_divide`. Values below 4 are clamped to 4. Both engines latch N at frame start, so changing it mid-frame has no effect until the next frame.
- TX states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1 and `uart_tx_ready`=1.
  - A byte is accepted when `uart_tx_valid` and `uart_tx_ready` are both high: the data is latched and the engine enters START.
  - Each state holds `txd` for N cycles. DATA repeats for each bit; STOP then returns to IDLE.
  - `uart_tx_valid` asserted while not ready is ignored and the byte is dropped.
- RX:
  - `rxd` passes through a 2-flop synchronizer, reset value 1.
  - States: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized low.
  - START waits N/2 cycles (integer divide) and re-samples. If the line is high, the edge is treated as a glitch and the engine returns to IDLE. If low, it enters DATA.
  - DATA samples each bit every N cycles at mid-bit.
  - STOP samples after N cycles:
    - high: update `uart_rx_data`, pulse `uart_rx_valid`.
    - low: pulse `uart_rx_err`, leave `uart_rx_data` unchanged, and wait in IDLE until the line is high before arming again.
- `uart_rx_data` holds its value between frames.

## Timing
- Reset values: `txd`=1, `uart_tx_ready`=0 while `rst`=0 and 1 from the first cycle after release; `uart_rx_data`=0, `uart_rx_valid`=0, `uart_rx_err`=0; both FSMs in IDLE.
- Reset mid-frame aborts the frame immediately; no partial valid or error is produced.
- TX latency: handshake at edge k → `txd` falls at edge k+1 (registered output). Bit j (j=0..DATA_WIDTH-1) starts at edge k+1+(j+1)·N. The stop bit starts at k+1+9N. `uart_tx_ready` rises at k+1+10N, and a new handshake may occur on that same edge.
- `uart_tx_ready` falls at edge k+1.
- RX latency: if `rxd` falls just before edge e, the synchronized low is seen at e+2. The stop bit is sampled, and valid/err asserted, at e+2+N/2+9N (±1 cycle of edge alignment). Both pulses last exactly one cycle.
- Back-to-back frames (stop bit followed immediately by a start bit) must be received without loss.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_WIDTH`=8, `WORD_SIZE`=32.
  - Minimum divide (4).
  - Simulation divide override `UART_DIVIDE_OVERRIDE_SIM` (16).
  - TX/RX state enum typedefs.
- Sub-modules `uart_tx` and `uart_rx` hold the two engines. `jpu_uart` is a thin wrapper around them.
- Helper sub-module `uart_bit_timer` (load N or N/2, count down, tick at 0) is instantiated once per engine.

## Test plan
- Loopback `txd`→`rxd`, N=16: send 0x41 ('A') → `txd` low 16 cycles, then bits 1,0,0,0,0,0,1,0 → `uart_rx_data`=0x41 with one `uart_rx_valid` pulse, `uart_rx_err`=0; ready returns 161 cycles after the handshake.
- Loopback, N=16: send "Aq\n" (0x41, 0x71, 0x0A), each byte issued on the first ready cycle → three valid pulses in order, no errors.
- Drive `rxd` frame 0x55 with stop bit forced low → one `uart_rx_err` pulse, no valid, `uart_rx_data` unchanged.
- `rxd` low pulse of 5 cycles, N=16 → no valid, no err, RX back in IDLE.
- Assert `uart_tx_valid` with 0x22 mid-frame of 0x11 → only 0x11 appears on the line.
- Assert `rst`=0 during the 4th data bit → `txd`=1 next cycle, ready=1 after release, receiver produces no pulse.
